// File: rtl/bsg_manycore_vcache_dma_block_mem_pkg.sv
// +----------------------------------------------------------------------+
// | bsg_manycore_vcache_dma_block_mem_pkg                                |
// | FSM state type and geometry helpers for the vcache DMA block memory. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package bsg_manycore_vcache_dma_block_mem_pkg;

  typedef enum logic [1:0] {
    e_idle    = 2'd0,
    e_rd_wait = 2'd1,
    e_rd_send = 2'd2,
    e_wr_recv = 2'd3
  } block_mem_state_e;

  function automatic int byte_offset_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int line_offset_width(input int block_size_in_words);
    return $clog2(block_size_in_words);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  localparam int DEFAULT_BYTE_OFFSET_W = byte_offset_width(32);
  localparam int DEFAULT_LINE_OFFSET_W = line_offset_width(8);

endpackage

`default_nettype wire

// File: rtl/bsg_nonsynth_mem_1r1w_comb.sv
// +----------------------------------------------------------------------+
// | bsg_nonsynth_mem_1r1w_comb                                           |
// | Zero-initialized word array: combinational read, clocked write.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bsg_nonsynth_mem_1r1w_comb #(
  parameter int width_p      = 32,
  parameter int els_p        = 2**16,
  parameter int addr_width_p = 16
) (
  input  logic                    clk_i,
  input  logic                    w_v_i,
  input  logic [addr_width_p-1:0] w_addr_i,
  input  logic [width_p-1:0]      w_data_i,
  input  logic [addr_width_p-1:0] r_addr_i,
  output logic [width_p-1:0]      r_data_o
);

  logic [width_p-1:0] mem_q [els_p] = '{default: '0};

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

`default_nettype wire

// File: rtl/bsg_manycore_vcache_dma_block_mem.sv
// +----------------------------------------------------------------------+
// | bsg_manycore_vcache_dma_block_mem                                    |
// | Services vcache line fill/evict DMA with a fixed read latency.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bsg_manycore_vcache_dma_block_mem
  import bsg_manycore_vcache_dma_block_mem_pkg::*;
#(
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int mem_els_p             = 2**16,
  parameter int read_delay_p          = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [addr_width_p:0]   dma_pkt_i,
  input  logic                    dma_pkt_v_i,
  output logic                    dma_pkt_yumi_o,
  output logic [data_width_p-1:0] dma_data_o,
  output logic                    dma_data_v_o,
  input  logic                    dma_data_ready_i,
  input  logic [data_width_p-1:0] dma_data_i,
  input  logic                    dma_data_v_i,
  output logic                    dma_data_yumi_o
);

  localparam int BYTE_W = byte_offset_width(data_width_p);
  localparam int LINE_W = line_offset_width(block_size_in_words_p);
  localparam int MEM_W  = $clog2(mem_els_p);
  localparam int CNT_W  = (LINE_W > 0) ? LINE_W : 1;
  localparam int DLY_W  = (read_delay_p > 0) ? $clog2(read_delay_p + 1) : 1;

  if (!is_pow2(data_width_p) || (data_width_p < 8) ||
      !is_pow2(block_size_in_words_p) || !is_pow2(mem_els_p)) begin : g_bad_params
    $error("bsg_manycore_vcache_dma_block_mem: widths/sizes must be powers of 2");
  end

  logic                    pkt_write;
  logic [addr_width_p-1:0] pkt_addr;
  logic [addr_width_p-1:0] unused_pkt_addr;
  logic [MEM_W-1:0]        pkt_base;

  assign {pkt_write, pkt_addr} = dma_pkt_i;
  assign unused_pkt_addr       = pkt_addr;
  // Word index truncated to the array size so high address bits alias.
  assign pkt_base = pkt_addr[BYTE_W +: MEM_W] & ~MEM_W'(block_size_in_words_p - 1);

  block_mem_state_e  state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [MEM_W-1:0]  base_q, base_d;

  logic                    cnt_last;
  logic [MEM_W-1:0]        beat_addr;
  logic [data_width_p-1:0] mem_rdata;
  logic                    mem_w_v;

  assign cnt_last  = (cnt_q == CNT_W'(block_size_in_words_p - 1));
  assign beat_addr = base_q + MEM_W'(cnt_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      dly_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    dly_d           = dly_q;
    base_d          = base_q;
    dma_pkt_yumi_o  = 1'b0;
    dma_data_v_o    = 1'b0;
    dma_data_yumi_o = 1'b0;
    mem_w_v         = 1'b0;
    unique case (state_q)
      e_idle: begin
        dma_pkt_yumi_o = dma_pkt_v_i & ~reset_i;
        if (dma_pkt_v_i) begin
          base_d = pkt_base;
          cnt_d  = '0;
          if (pkt_write) begin
            state_d = e_wr_recv;
          end else if (read_delay_p == 0) begin
            state_d = e_rd_send;
          end else begin
            state_d = e_rd_wait;
            dly_d   = DLY_W'(read_delay_p);
          end
        end
      end
      e_rd_wait: begin
        dly_d = dly_q - DLY_W'(1);
        if (dly_q == DLY_W'(1)) begin
          state_d = e_rd_send;
        end
      end
      e_rd_send: begin
        dma_data_v_o = 1'b1;
        if (dma_data_ready_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = e_idle;
          end
        end
      end
      e_wr_recv: begin
        dma_data_yumi_o = dma_data_v_i;
        mem_w_v         = dma_data_v_i;
        if (dma_data_v_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = e_idle;
          end
        end
      end
      default: state_d = e_idle;
    endcase
  end

  assign dma_data_o = dma_data_v_o ? mem_rdata : '0;

  bsg_nonsynth_mem_1r1w_comb #(
    .width_p      (data_width_p),
    .els_p        (mem_els_p),
    .addr_width_p (MEM_W)
  ) mem (
    .clk_i    (clk_i),
    .w_v_i    (mem_w_v),
    .w_addr_i (beat_addr),
    .w_data_i (dma_data_i),
    .r_addr_i (beat_addr),
    .r_data_o (mem_rdata)
  );

  a_ready_known: assert property (@(posedge clk_i) disable iff (reset_i)
    dma_data_v_o |-> !$isunknown(dma_data_ready_i));

endmodule

`default_nettype wire

// File: tb/tb_bsg_manycore_vcache_dma_block_mem.sv
// +----------------------------------------------------------------------+
// | tb_bsg_manycore_vcache_dma_block_mem                                 |
// | Scenario tasks checked against a flat word-array reference model.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bsg_manycore_vcache_dma_block_mem;

  localparam int DELAY = 4;
  localparam int ELS   = 2**16;

  typedef logic [31:0] line_t [8];

  logic        clk = 1'b0;
  logic        reset_i;
  logic [32:0] dma_pkt_i;
  logic        dma_pkt_v_i;
  logic        dma_pkt_yumi_o;
  logic [31:0] dma_data_o;
  logic        dma_data_v_o;
  logic        dma_data_ready_i;
  logic [31:0] dma_data_i;
  logic        dma_data_v_i;
  logic        dma_data_yumi_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [ELS];

  always #5 clk = ~clk;

  bsg_manycore_vcache_dma_block_mem #(
    .addr_width_p          (32),
    .data_width_p          (32),
    .block_size_in_words_p (8),
    .mem_els_p             (ELS),
    .read_delay_p          (DELAY)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .dma_pkt_i        (dma_pkt_i),
    .dma_pkt_v_i      (dma_pkt_v_i),
    .dma_pkt_yumi_o   (dma_pkt_yumi_o),
    .dma_data_o       (dma_data_o),
    .dma_data_v_o     (dma_data_v_o),
    .dma_data_ready_i (dma_data_ready_i),
    .dma_data_i       (dma_data_i),
    .dma_data_v_i     (dma_data_v_i),
    .dma_data_yumi_o  (dma_data_yumi_o)
  );

  // Memory word that beat i of a packet at byte address addr lands on.
  function automatic int model_idx(input logic [31:0] addr, input int i);
    return int'((((addr >> 2) & ~32'd7) + 32'(i)) % ELS);
  endfunction

  task automatic run_read(input logic [31:0] addr, input int mode,
                          output line_t words, output int acc, output int lat,
                          output int vcyc, output int held_bad, output int tail_v,
                          output bit to);
    int n = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [31:0] held = '0;
    acc = 0; lat = -1; vcyc = 0; held_bad = 0; to = 0;
    for (int i = 0; i < 8; i++) words[i] = 'x;
    @(negedge clk);
    dma_pkt_v_i = 1'b1; dma_pkt_i = {1'b0, addr}; dma_data_ready_i = 1'b0;
    #1 acc = int'(dma_pkt_yumi_o);
    while (n < 8 && !to) begin
      @(negedge clk);
      dma_pkt_v_i = 1'b0;
      cyc++;
      case (mode)
        0:       dma_data_ready_i = 1'b1;
        1:       dma_data_ready_i = (cyc % 3 == 0);
        default: dma_data_ready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (dma_data_v_o) begin
        if (lat < 0) lat = cyc;
        vcyc++;
        if (stalled && dma_data_o !== held) held_bad++;
        if (dma_data_ready_i) begin
          words[n] = dma_data_o; n++; stalled = 0;
        end else begin
          stalled = 1; held = dma_data_o;
        end
      end
      if (cyc > 300) to = 1;
    end
    @(negedge clk);
    dma_data_ready_i = 1'b0;
    #1 tail_v = int'(dma_data_v_o);
  endtask

  task automatic run_write(input logic [31:0] addr, input line_t data, input int nwords,
                           input int gapmode, input bit second_pkt,
                           output int acc, output int acc_dyumi, output int bad_pkt_yumi,
                           output int bad_dyumi, output bit to);
    int k = 0;
    int cyc = 0;
    acc = 0; acc_dyumi = 0; bad_pkt_yumi = 0; bad_dyumi = 0; to = 0;
    @(negedge clk);
    dma_pkt_v_i = 1'b1; dma_pkt_i = {1'b1, addr};
    dma_data_v_i = 1'b1; dma_data_i = 32'hDEAD_BEEF;
    #1;
    acc = int'(dma_pkt_yumi_o);
    acc_dyumi = int'(dma_data_yumi_o);
    while (k < nwords && !to) begin
      @(negedge clk);
      cyc++;
      dma_pkt_v_i = second_pkt;
      dma_pkt_i = {1'b0, $urandom()};
      case (gapmode)
        0:       dma_data_v_i = 1'b1;
        1:       dma_data_v_i = (cyc % 3 == 1);
        default: dma_data_v_i = 1'($urandom_range(0, 1));
      endcase
      dma_data_i = data[k];
      #1;
      if (dma_pkt_yumi_o) bad_pkt_yumi++;
      if (dma_data_yumi_o !== dma_data_v_i) bad_dyumi++;
      if (dma_data_yumi_o === 1'b1) begin
        ref_mem[model_idx(addr, k)] = data[k];
        k++;
      end
      if (cyc > 300) to = 1;
    end
    @(posedge clk);
    #1;
    dma_pkt_v_i = 1'b0; dma_data_v_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; dma_pkt_v_i = 1'b1; dma_pkt_i = '0;
    dma_data_v_i = 1'b1; dma_data_i = '1; dma_data_ready_i = 1'b1;
    #3;
    n_cmp++;
    if ({dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o, dma_data_o} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h required=0",
               {dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o, dma_data_o});
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o, dma_data_o} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_held got=%h required=0",
               {dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o, dma_data_o});
    end
    dma_pkt_v_i = 1'b0; dma_data_v_i = 1'b0; dma_data_ready_i = 1'b0;
    reset_i = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [31:0] addr, input int mode);
    line_t w;
    int acc, lat, vcyc, held_bad, tail_v;
    bit to;
    run_read(addr, mode, w, acc, lat, vcyc, held_bad, tail_v, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL %s_timeout got=timeout required=8 words", name); end
    n_cmp++;
    if (acc != 1) begin n_bad++; $display("FAIL %s_accept got=%0d required=1", name, acc); end
    n_cmp++;
    if (lat != DELAY + 1) begin n_bad++; $display("FAIL %s_latency got=%0d required=%0d", name, lat, DELAY + 1); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (w[i] !== ref_mem[model_idx(addr, i)]) begin
        n_bad++;
        $display("FAIL %s_word%0d got=%h required=%h", name, i, w[i], ref_mem[model_idx(addr, i)]);
      end
    end
    if (mode == 0) begin
      n_cmp++;
      if (vcyc != 8) begin n_bad++; $display("FAIL %s_valid_cycles got=%0d required=8", name, vcyc); end
    end
    n_cmp++;
    if (held_bad != 0) begin n_bad++; $display("FAIL %s_stall_hold got=%0d changes required=0", name, held_bad); end
    n_cmp++;
    if (tail_v != 0) begin n_bad++; $display("FAIL %s_idle_after got=%0d required=0", name, tail_v); end
  endtask

  task automatic check_write(input string name, input logic [31:0] addr, input line_t d,
                             input int gapmode, input bit second_pkt);
    int acc, acc_dyumi, bad_pkt, bad_dy;
    bit to;
    run_write(addr, d, 8, gapmode, second_pkt, acc, acc_dyumi, bad_pkt, bad_dy, to);
    n_cmp++;
    if (to || acc != 1) begin n_bad++; $display("FAIL %s_accept got=%0d to=%0d required=1", name, acc, to); end
    n_cmp++;
    if (acc_dyumi != 0) begin n_bad++; $display("FAIL %s_accept_cycle_yumi got=%0d required=0", name, acc_dyumi); end
    n_cmp++;
    if (bad_dy != 0) begin n_bad++; $display("FAIL %s_yumi_follows_v got=%0d errors required=0", name, bad_dy); end
    n_cmp++;
    if (bad_pkt != 0) begin n_bad++; $display("FAIL %s_pkt_yumi_busy got=%0d required=0", name, bad_pkt); end
  endtask

  task automatic test_read_after_reset();
    check_read("rd_zero", 32'h0, 0);
  endtask

  task automatic test_write_read();
    line_t d;
    for (int i = 0; i < 8; i++) d[i] = 32'hA0 + 32'(i);
    check_write("wr_a0", 32'h100, d, 0, 1'b0);
    check_read("rd_unaligned", 32'h104, 0);
  endtask

  task automatic test_stall();
    line_t d;
    for (int i = 0; i < 8; i++) d[i] = 32'hB0 + 32'(i);
    check_write("wr_b0", 32'h200, d, 0, 1'b0);
    check_read("rd_stall", 32'h200, 1);
  endtask

  task automatic test_evict_gaps();
    line_t d;
    for (int i = 0; i < 8; i++) d[i] = $urandom();
    check_write("wr_gaps", 32'h340, d, 1, 1'b1);
    check_read("rd_gaps", 32'h340, 0);
  endtask

  task automatic test_addr_wrap();
    line_t d;
    for (int i = 0; i < 8; i++) d[i] = 32'hC0DE_0000 + 32'(i);
    check_write("wr_wrap", 32'h0004_0000, d, 0, 1'b0);
    check_read("rd_wrap", 32'h0, 0);
  endtask

  task automatic test_midop_reset();
    line_t olds, news;
    int acc, acc_dyumi, bad_pkt, bad_dy;
    bit to;
    for (int i = 0; i < 8; i++) begin olds[i] = $urandom(); news[i] = $urandom(); end
    check_write("wr_old", 32'h480, olds, 0, 1'b0);
    run_write(32'h480, news, 3, 0, 1'b0, acc, acc_dyumi, bad_pkt, bad_dy, to);
    @(negedge clk);
    dma_data_v_i = 1'b1; dma_data_i = news[3];
    #1;
    n_cmp++;
    if (dma_data_yumi_o !== 1'b1) begin n_bad++; $display("FAIL midop_busy_yumi got=%b required=1", dma_data_yumi_o); end
    reset_i = 1'b1;
    #1;
    n_cmp++;
    if ({dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL midop_async_drop got=%b required=000", {dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o});
    end
    repeat (2) @(negedge clk);
    dma_data_v_i = 1'b0;
    reset_i = 1'b0;
    check_read("rd_midop", 32'h480, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      logic [31:0] a;
      line_t d;
      a = $urandom();
      if (t % 2 == 0) begin
        for (int i = 0; i < 8; i++) d[i] = $urandom();
        check_write("rnd_wr", a, d, 2, 1'($urandom_range(0, 1)));
      end
      check_read("rnd_rd", (t % 3 == 0) ? a : $urandom(), 2);
    end
  endtask

  initial begin
    for (int i = 0; i < ELS; i++) ref_mem[i] = '0;
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_stall();
    test_evict_gaps();
    test_addr_wrap();
    test_midop_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
